// File: rtl/uart_rx_packet_decoder.sv
// uart_rx_packet_decoder: assembles header-flagged UART byte streams into
// fixed-length packets with an optional additive checksum and issues one
// write per good packet. Headers resynchronise the decoder at any point;
// stalled packets are dropped after an inter-byte timeout. Framing,
// checksum and timeout errors are tallied in saturating counters.
module uart_rx_packet_decoder #(
  parameter int DATA_BYTES     = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int CHECKSUM_EN    = 1,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [8:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  input  logic                    err_clear,
  output logic [CNT_WIDTH-1:0]    err_sync_cnt,
  output logic [CNT_WIDTH-1:0]    err_chk_cnt,
  output logic [CNT_WIDTH-1:0]    err_timeout_cnt
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  // gap counter only has to reach TIMEOUT_CYCLES-1
  localparam int GW    = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0]    CNT_LAST = 4'(DATA_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK, S_OUT} state_t;

  state_t          state;
  logic [7:0]      sum;
  logic [3:0]      cnt;
  logic [GW-1:0]   gap;
  logic            acc, hdr, in_pkt, timeout;
  logic [7:0]      b;
  logic            inc_sync, inc_chk, inc_to;

  assign in_ready = (state != S_OUT);
  assign acc      = in_valid & in_ready;
  assign hdr      = in_data[8];
  assign b        = in_data[7:0];
  assign in_pkt   = (state == S_DATA) || (state == S_CHK);
  // an accepted byte in the timeout cycle takes precedence
  assign timeout  = TO_EN && in_pkt && !acc && (gap == GAP_LAST);

  // error event decode for the counters
  always_comb begin
    inc_sync = acc && (((state == S_IDLE) && !hdr) || (in_pkt && hdr));
    inc_chk  = acc && (state == S_CHK) && !hdr && (b != sum);
    inc_to   = timeout;
  end

  // packet FSM: framing, payload shift, checksum, output hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      sum      <= '0;
      cnt      <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc && hdr) begin
            wr_addr <= b[ADDR_WIDTH-1:0];
            sum     <= b;
            cnt     <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA, S_CHK: begin
          if (acc && hdr) begin
            // header mid-packet: restart on this byte
            wr_addr <= b[ADDR_WIDTH-1:0];
            sum     <= b;
            cnt     <= '0;
            state   <= S_DATA;
          end else if (acc && (state == S_DATA)) begin
            wr_data <= DW'({wr_data, b});
            sum     <= sum + b;
            cnt     <= cnt + 4'd1;
            if (cnt == CNT_LAST) begin
              if (CHECKSUM_EN != 0) begin
                state <= S_CHK;
              end else begin
                state    <= S_OUT;
                wr_valid <= 1'b1;
              end
            end
          end else if (acc) begin
            if (b == sum) begin
              state    <= S_OUT;
              wr_valid <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // inter-byte gap counter, live only inside a packet
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  gap <= '0;
    else if (!in_pkt || acc || timeout) gap <= '0;
    else                        gap <= gap + GW'(1);
  end

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c,
                                                input logic inc, input logic clr);
    if (clr)                return '0;
    if (inc && (c != '1))   return c + CNT_WIDTH'(1);
    return c;
  endfunction

  // saturating error counters, clear wins over increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_sync_cnt    <= '0;
      err_chk_cnt     <= '0;
      err_timeout_cnt <= '0;
    end else begin
      err_sync_cnt    <= bump(err_sync_cnt,    inc_sync, err_clear);
      err_chk_cnt     <= bump(err_chk_cnt,     inc_chk,  err_clear);
      err_timeout_cnt <= bump(err_timeout_cnt, inc_to,   err_clear);
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_decoder.sv
// Directed bench: instance A is the 4-byte/checksum decoder with a 16-cycle
// timeout, instance B the 1-byte/no-checksum decoder with 2-bit counters.
module tb_uart_rx_packet_decoder;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // instance A
  logic [8:0]  a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_ready;
  logic [7:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_wr_valid, a_wr_ready = 1'b1, a_err_clear = 1'b0;
  logic [15:0] a_sync, a_chk, a_to;

  // instance B
  logic [8:0]  b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [7:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic        b_wr_valid, b_wr_ready = 1'b1, b_err_clear = 1'b0;
  logic [1:0]  b_sync, b_chk, b_to;

  uart_rx_packet_decoder #(.DATA_BYTES(4), .ADDR_WIDTH(8), .CHECKSUM_EN(1),
                           .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .err_clear(a_err_clear),
    .err_sync_cnt(a_sync), .err_chk_cnt(a_chk), .err_timeout_cnt(a_to));

  uart_rx_packet_decoder #(.DATA_BYTES(1), .ADDR_WIDTH(8), .CHECKSUM_EN(0),
                           .CNT_WIDTH(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .err_clear(b_err_clear),
    .err_sync_cnt(b_sync), .err_chk_cnt(b_chk), .err_timeout_cnt(b_to));

  int n_tests = 0;
  int n_fail  = 0;

  // completed write handshakes
  logic [7:0]  aq_addr[$];
  logic [31:0] aq_data[$];
  int          b_wr_cnt = 0;

  always @(posedge clk) begin
    if (a_wr_valid && a_wr_ready) begin
      aq_addr.push_back(a_wr_addr);
      aq_data.push_back(a_wr_data);
    end
    if (b_wr_valid && b_wr_ready) b_wr_cnt <= b_wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present one byte from a negedge; returns at the negedge after acceptance
  task automatic send(input bit sel_b, input logic [8:0] v);
    int n = 0;
    if (sel_b) begin b_in_data = v; b_in_valid = 1'b1; end
    else       begin a_in_data = v; a_in_valid = 1'b1; end
    while (!(sel_b ? b_in_ready : a_in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait", 64'(n < 100), 64'd1);
    @(negedge clk);
    if (sel_b) b_in_valid = 1'b0;
    else       a_in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [8:0] p[$]);
    foreach (p[i]) send(1'b0, p[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_wr_valid", a_wr_valid, 0);
    chk("rst_wr_addr",  a_wr_addr, 0);
    chk("rst_wr_data",  a_wr_data, 0);
    chk("rst_cnts",     {a_sync, a_chk, a_to}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // good packet, checksum 0x4A
    send_pkt('{9'h112, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, 9'h04A});
    chk("t1_valid_lat", a_wr_valid, 1);
    chk("t1_addr", a_wr_addr, 8'h12);
    chk("t1_data", a_wr_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_valid_drop", a_wr_valid, 0);
    chk("t1_nwr", aq_addr.size(), 1);
    chk("t1_cnts", {a_sync, a_chk, a_to}, 0);

    // bad checksum, then good packet
    send_pkt('{9'h112, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, 9'h04B});
    chk("t2_no_valid", a_wr_valid, 0);
    chk("t2_chk_cnt", a_chk, 1);
    send_pkt('{9'h112, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, 9'h04A});
    @(negedge clk);
    chk("t2_nwr", aq_addr.size(), 2);

    // stray byte + truncated packet, then header 0x34 (sum 0x3E)
    send_pkt('{9'h005, 9'h112, 9'h001, 9'h002,
               9'h134, 9'h001, 9'h002, 9'h003, 9'h004, 9'h03E});
    @(negedge clk);
    chk("t3_sync_cnt", a_sync, 2);
    chk("t3_nwr", aq_addr.size(), 3);
    chk("t3_addr", (aq_addr.size() > 2) ? aq_addr[2] : 8'hxx, 8'h34);
    chk("t3_data", (aq_data.size() > 2) ? aq_data[2] : 32'hx, 32'h01020304);

    // backpressure: packet 0x55 (sum 0xFF) held while next header waits
    a_wr_ready = 1'b0;
    send_pkt('{9'h155, 9'h011, 9'h022, 9'h033, 9'h044, 9'h0FF});
    a_in_data = 9'h166; a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_in_ready", a_in_ready, 0);
      chk("t4_hold", {a_wr_valid, a_wr_addr, a_wr_data}, {1'b1, 8'h55, 32'h11223344});
    end
    a_wr_ready = 1'b1;
    send_pkt('{9'h166, 9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, 9'h050});
    @(negedge clk);
    chk("t4_nwr", aq_addr.size(), 5);
    chk("t4_first", (aq_data.size() > 3) ? {aq_addr[3], aq_data[3]} : 40'hx, {8'h55, 32'h11223344});
    chk("t4_next",  (aq_data.size() > 4) ? {aq_addr[4], aq_data[4]} : 40'hx, {8'h66, 32'hA1B2C3D4});

    // timeout: 15-cycle gap survives (sum 0xA1)
    send_pkt('{9'h101, 9'h010, 9'h020});
    repeat (15) @(negedge clk);
    send_pkt('{9'h030, 9'h040, 9'h0A1});
    @(negedge clk);
    chk("t5_gap15_nwr", aq_addr.size(), 6);
    chk("t5_gap15_to", a_to, 0);
    // 16-cycle gap aborts; trailing bytes are stray
    send_pkt('{9'h101, 9'h010, 9'h020});
    repeat (16) @(negedge clk);
    send_pkt('{9'h030, 9'h040, 9'h0A1});
    @(negedge clk);
    chk("t5_gap16_nwr", aq_addr.size(), 6);
    chk("t5_to_cnt", a_to, 1);
    chk("t5_sync_cnt", a_sync, 5);
    chk("t5_chk_cnt", a_chk, 1);

    // instance B: 1-byte packets, no checksum
    send(1'b1, 9'h17F);
    send(1'b1, 9'h0A5);
    chk("b_valid", b_wr_valid, 1);
    chk("b_addr", b_wr_addr, 8'h7F);
    chk("b_data", b_wr_data, 8'hA5);
    for (int i = 0; i < 5; i++) send(1'b1, 9'(i));
    chk("b_sync_sat", b_sync, 3);
    chk("b_nwr", b_wr_cnt, 1);
    b_err_clear = 1'b1;
    send(1'b1, 9'h001);
    b_err_clear = 1'b0;
    chk("b_clear_wins", b_sync, 0);

    // reset while B is holding a write and A has counts
    b_wr_ready = 1'b0;
    send(1'b1, 9'h122);
    send(1'b1, 9'h0CC);
    chk("b_pre_rst", {b_wr_valid, b_wr_addr, b_wr_data}, {1'b1, 8'h22, 8'hCC});
    b_in_data = 9'h133; b_in_valid = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("rst_b_out", {b_wr_valid, b_wr_addr, b_wr_data}, 0);
    chk("rst_b_ready", b_in_ready, 1);
    chk("rst_a_cnts", {a_sync, a_chk, a_to}, 0);
    b_in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    b_wr_ready = 1'b1;
    @(negedge clk);
    // partial packet is gone: a lone payload byte is stray
    send(1'b1, 9'h0A5);
    @(negedge clk);
    chk("post_rst_stray", b_sync, 1);
    chk("post_rst_nwr", b_wr_cnt, 1);
    chk("post_rst_valid", b_wr_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_packet_decoder.md
# uart_rx_packet_decoder

Parametrised successor to the fixed 1-address + 4-data-byte UART receive decoder. It consumes the 9-bit word stream from the UART receiver / sync FIFO, where bit 8 flags a header (address) byte. It assembles packets of configurable length, with optional checksum, and issues one write per good packet on a valid/ready bus. It also adds header-based resynchronisation, an inter-byte timeout and saturating error counters.

## Interface
- DATA_BYTES, 4, payload bytes per packet (1..8), sent MSB first
- ADDR_WIDTH, 8, write address width (1..8), taken from header bits [ADDR_WIDTH-1:0]
- CHECKSUM_EN, 1, 1: a checksum byte follows the payload; 0: no checksum byte
- TIMEOUT_CYCLES, 100000, idle cycles mid-packet that abort the packet; 0 disables the timeout
- CNT_WIDTH, 16, width of each error counter

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_data  in  9  bit 8 = header flag, bits [7:0] = byte
- in_valid  in  1  stream valid
- in_ready  out  1  stream ready
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  8*DATA_BYTES  write data; first payload byte in the MSBs
- wr_valid  out  1  write valid
- wr_ready  in  1  write ready
- err_clear  in  1  synchronous clear of all error counters
- err_sync_cnt  out  CNT_WIDTH  stray or truncated packets
- err_chk_cnt  out  CNT_WIDTH  checksum failures
- err_timeout_cnt  out  CNT_WIDTH  timeouts

## Operation
- A byte is accepted when in_valid & in_ready.
- in_ready = (state != OUT). It is combinational from state only.
- Checksum = 8-bit modulo sum of header[7:0] and all payload bytes. The checksum byte must carry flag 0.
- IDLE:
  - Flag-1 byte: latch the address, sum = byte, byte counter = 0, go to DATA.
  - Flag-0 byte: discard it and increment err_sync_cnt.
- DATA:
  - Flag-0 byte: shift it into the data register (`data <= {data[8*DATA_BYTES-9:0], byte}`), add it to the sum, increment the counter.
  - On the DATA_BYTES-th payload byte: go to CHK if CHECKSUM_EN, else go to OUT.
- CHK:
  - Flag-0 byte equal to the sum: go to OUT.
  - Flag-0 byte not equal to the sum: increment err_chk_cnt, go to IDLE.
- Header mid-packet (flag-1 byte in DATA or CHK):
  - Drop the partial packet and increment err_sync_cnt.
  - The same byte is the new header: latch the address, reload the sum, clear the counter, stay in/enter DATA.
- OUT:
  - wr_valid = 1, with wr_addr/wr_data held stable.
  - On wr_valid & wr_ready: go to IDLE.
- Timeout (DATA/CHK only):
  - A gap counter clears on every accepted byte and on entry to DATA.
  - It increments on every other cycle spent in DATA/CHK.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle: go to IDLE, increment err_timeout_cnt.
  - An accepted byte in the same cycle as the timeout wins; no timeout occurs.
- Error counters:
  - Saturate at all-ones.
  - err_clear has priority over any same-cycle increment.
  - Counters are not cleared by packet activity.

## Timing
- Reset (rstn low, asynchronous): state = IDLE, so in_ready = 1.
- Reset values: wr_valid = 0, wr_addr = 0, wr_data = 0, all counters = 0, sum/byte/gap counters = 0.
- Reset mid-packet: the partial packet is lost and no write is issued.
- Deassertion is sampled at the next clk edge.
- Throughput: one byte per cycle in IDLE/DATA/CHK.
- Latency: wr_valid rises on the clock edge that accepts the last byte (checksum byte, or last payload byte when CHECKSUM_EN = 0). It is visible the following cycle.
- A handshake in the first OUT cycle returns to IDLE. Minimum packet period = DATA_BYTES + 1 + CHECKSUM_EN + 1 cycles.
- While in OUT: in_ready = 0, so upstream bytes wait in the FIFO and none are lost.
- wr_valid never deasserts without a handshake.

## Test plan
- Defaults: in_data 0x112, 0x0DE, 0x0AD, 0x0BE, 0x0EF, 0x04A back-to-back with wr_ready = 1 -> exactly one write, wr_addr = 0x12, wr_data = 0xDEADBEEF, asserted 1 cycle after the 0x04A accept; all counters 0.
- Same packet with checksum byte 0x04B -> no wr_valid, err_chk_cnt = 1. A following correct packet is written normally.
- Stream 0x005, 0x112, 0x001, 0x002, then a full valid packet with header 0x134 -> err_sync_cnt = 2 (stray byte + truncated packet), one write with wr_addr = 0x34.
- Backpressure: hold wr_ready = 0 for 10 cycles after wr_valid -> in_ready = 0, wr_addr/wr_data stable, the next packet's bytes are held upstream. Raise wr_ready -> one handshake, then the next packet is decoded intact.
- TIMEOUT_CYCLES = 16: header + 2 payload bytes, then a 15-cycle gap and the rest of the packet -> the write succeeds. Repeat with a 16-cycle gap -> err_timeout_cnt = 1, no write, the remaining bytes count as stray in err_sync_cnt.
- DATA_BYTES = 1, CHECKSUM_EN = 0, CNT_WIDTH = 2: 0x17F, 0x0A5 -> wr_addr = 0x7F, wr_data = 0xA5. Five stray bytes -> err_sync_cnt saturates at 3. err_clear together with a stray byte -> counter = 0. Assert rstn mid-packet -> all outputs return to their reset values immediately.
